task2_4_func: RTL and testbench
===============================

Name: task2_4_func

Overview:
- Three-input Boolean function unit for the lab logic tasks.
- Evaluates F(X,Y,Z) combinationally from a parameterised 8-entry truth table. The default table is the majority function.
- Also provides a registered copy of F, a minterm-coverage tracker and a saturating counter of F rising edges, so a bench sweeping all 8 input codes can self-check.
- Sits as a leaf block; all inputs are driven directly from a stimulus source.

Parameters:
- TRUTH_TABLE, 8'b1110_1000, bit i = F for minterm i, where i = {X,Y,Z}. Default: F = XY + YZ + XZ (majority).
- CNT_W, 8, width of the rising-edge counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- X  in  1  function input, MSB of minterm index.
- Y  in  1  function input, middle bit.
- Z  in  1  function input, LSB.
- F  out  1  combinational function output = TRUTH_TABLE[{X,Y,Z}].
- F_q  out  1  F registered on clk.
- idx_q  out  3  registered minterm index {X,Y,Z}.
- seen  out  8  sticky coverage; bit i set once minterm i has been sampled.
- all_seen  out  1  high when seen == 8'hFF (combinational from seen).
- rise_cnt  out  CNT_W  count of 0->1 transitions of F_q, saturating.

Behaviour:
- F is purely combinational with zero latency. It is independent of clk and rst, and is valid whenever X/Y/Z are known.
- With the default table: F=1 for {011,101,110,111}, F=0 otherwise.
- Reset (rst=1, asynchronous assert, released synchronously by design usage): F_q=0, idx_q=0, seen=0, rise_cnt=0.
- Each rising clk edge with rst=0:
  - F_q <= F
  - idx_q <= {X,Y,Z}
  - seen[{X,Y,Z}] <= 1
  - if F_q==0 and F==1, rise_cnt <= rise_cnt+1, unless already all-ones (saturate, no wrap).
- Latency: F_q, idx_q and seen update 1 cycle after input change. rise_cnt increments on the same edge that F_q goes 0->1.
- Inputs changing several times between edges: only the value at the edge is sampled. F follows every change.
- Reset mid-sweep clears coverage and counter immediately. The next edge after release re-samples.
- X/Y/Z as X or Z states: F propagates X. Registered state is not protected (no requirement).

Optional Feature:
- Macro TASK2_4_SOP_CHECK_EN.
- When defined:
  - Add output err (1 bit, reset 0).
  - Implement F independently as an explicit sum-of-products gate network derived from TRUTH_TABLE via a generate loop over minterms.
  - On each clk edge, if the SOP result differs from the LUT F, set err; err is sticky until rst.
- When undefined: no err port, no SOP logic. All other behaviour is identical.

Decomposition:
- Package task2_4_pkg:
  - localparam MAJ_TT = 8'b1110_1000
  - localparam N_MINTERMS = 8
  - function minterm_idx(x,y,z) returning 3 bits.
- One sub-module is natural: task2_4_lut (pure combinational TRUTH_TABLE lookup, parameter TRUTH_TABLE). It is reused by the SOP checker's reference path.
- Registers, coverage and counter stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles, inputs 000 -> F_q=0, seen=8'h00, rise_cnt=0, all_seen=0.
- Combinational sweep: apply 000,001,...,111, 10 ns apart -> F = 0,0,0,1,0,1,1,1 within each step, no clock dependence.
- Registered sweep: same sequence, one code per clock:
  - F_q lags F by 1 cycle; idx_q matches the prior code.
  - seen reaches 8'hFF and all_seen=1 after the 8th edge.
  - rise_cnt=2 (rises at 011 and at 101).
- Saturation: CNT_W=2, toggle inputs 000<->111 for 6 cycles -> rise_cnt stops at 3.
- Mid-sweep reset: assert rst after codes 000..011 -> seen=0 and rise_cnt=0 immediately (asynchronous). Resume at 100 -> seen=8'h10 after next edge.
- TASK2_4_SOP_CHECK_EN defined: full sweep with default table -> err stays 0. Bench forces the LUT path for one edge -> err=1 and remains 1 until rst.

Source files
------------

// File: rtl/task2_4_pkg.sv
// Shared constants and helpers for the three-input Boolean function unit.
// The majority truth table here is the default value of TRUTH_TABLE.
package task2_4_pkg;

    localparam logic [7:0] MAJ_TT     = 8'b1110_1000;
    localparam int         N_MINTERMS = 8;

    // X is the most significant bit of the minterm index.
    function automatic logic [2:0] minterm_idx(input logic x, input logic y, input logic z);
        return {x, y, z};
    endfunction

endpackage

// File: rtl/task2_4_lut.sv
// Pure combinational truth-table lookup: f_o = TRUTH_TABLE[idx_i].
// The top uses it as the primary F path and as the reference for the SOP cross-check.
module task2_4_lut #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000
) (
    input  logic [2:0] idx_i,
    output logic       f_o
);

    assign f_o = TRUTH_TABLE[idx_i];

endmodule

// File: rtl/task2_4_func.sv
// Three-input function unit: LUT-evaluated F, registered F/index, minterm coverage, saturating rise counter.
// Defining TASK2_4_SOP_CHECK_EN adds an independent sum-of-products F and a sticky mismatch flag err.
module task2_4_func
    import task2_4_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = MAJ_TT,
    parameter int         CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  X,
    input  logic                  Y,
    input  logic                  Z,
    output logic                  F,
    output logic                  F_q,
    output logic [2:0]            idx_q,
    output logic [N_MINTERMS-1:0] seen,
    output logic                  all_seen,
`ifdef TASK2_4_SOP_CHECK_EN
    output logic                  err,
`endif
    output logic [CNT_W-1:0]      rise_cnt
);

    logic [2:0]            idx;
    logic                  fLut;
    logic                  fOut_q,    fOut_d;
    logic [2:0]            idxReg_q,  idxReg_d;
    logic [N_MINTERMS-1:0] seen_q,    seen_d;
    logic [CNT_W-1:0]      riseCnt_q, riseCnt_d;

    assign idx = minterm_idx(X, Y, Z);

    task2_4_lut #(
        .TRUTH_TABLE(TRUTH_TABLE)
    ) u_lut (
        .idx_i(idx),
        .f_o  (fLut)
    );

    assign F = fLut;

    // A rise is F_q currently low while the value about to be captured is high.
    always_comb begin
        fOut_d    = fLut;
        idxReg_d  = idx;
        seen_d    = seen_q;
        seen_d[idx] = 1'b1;
        riseCnt_d = riseCnt_q;
        if (!fOut_q && fLut && (riseCnt_q != {CNT_W{1'b1}})) begin
            riseCnt_d = riseCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fOut_q    <= 1'b0;
            idxReg_q  <= 3'd0;
            seen_q    <= '0;
            riseCnt_q <= '0;
        end else begin
            fOut_q    <= fOut_d;
            idxReg_q  <= idxReg_d;
            seen_q    <= seen_d;
            riseCnt_q <= riseCnt_d;
        end
    end

    assign F_q      = fOut_q;
    assign idx_q    = idxReg_q;
    assign seen     = seen_q;
    assign all_seen = (seen_q == {N_MINTERMS{1'b1}});
    assign rise_cnt = riseCnt_q;

`ifdef TASK2_4_SOP_CHECK_EN
    logic [N_MINTERMS-1:0] sopTerm;
    logic                  sopF;
    logic                  err_q, err_d;

    // One product term per on-set minterm, each built from true/complemented literals.
    for (genvar m = 0; m < N_MINTERMS; m++) begin : g_sop
        localparam logic [2:0] M = 3'(m);
        if (TRUTH_TABLE[m]) begin : g_on
            assign sopTerm[m] = (X ~^ M[2]) & (Y ~^ M[1]) & (Z ~^ M[0]);
        end else begin : g_off
            assign sopTerm[m] = 1'b0;
        end
    end

    assign sopF = |sopTerm;

    always_comb begin
        err_d = err_q | (sopF != fLut);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_task2_4_func.sv
// Self-checking bench for task2_4_func: directed sweeps plus random codes against a behavioural model.
// A second instance with CNT_W=2 exercises counter saturation on the same stimulus.
module tb_task2_4_func;

    logic       clk = 1'b0;
    logic       rst;
    logic       X, Y, Z;
    logic       F, F_q, all_seen;
    logic [2:0] idx_q;
    logic [7:0] seen;
    logic [7:0] rise_cnt;
    logic       sF, sF_q, sAll;
    logic [2:0] sIdx;
    logic [7:0] sSeen;
    logic [1:0] sRise;
`ifdef TASK2_4_SOP_CHECK_EN
    logic       err, sErr;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic       mFq;
    logic [2:0] mIdx;
    logic [7:0] mSeen;
    int         mRises;

    task2_4_func dut (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .Z(Z),
        .F(F), .F_q(F_q), .idx_q(idx_q), .seen(seen), .all_seen(all_seen),
`ifdef TASK2_4_SOP_CHECK_EN
        .err(err),
`endif
        .rise_cnt(rise_cnt)
    );

    task2_4_func #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .Z(Z),
        .F(sF), .F_q(sF_q), .idx_q(sIdx), .seen(sSeen), .all_seen(sAll),
`ifdef TASK2_4_SOP_CHECK_EN
        .err(sErr),
`endif
        .rise_cnt(sRise)
    );

    always #5 clk = ~clk;

    // Majority: F is true when at least two of the three inputs are true.
    function automatic logic refF(input logic [2:0] c);
        return (int'(c[2]) + int'(c[1]) + int'(c[0])) >= 2;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic modelClear();
        mFq = 1'b0; mIdx = 3'd0; mSeen = 8'h00; mRises = 0;
    endtask

    // Advance one rising edge, update the model, then settle just past the edge.
    task automatic clockEdge();
        logic [2:0] c;
        logic       f;
        @(posedge clk);
        c = {X, Y, Z};
        f = refF(c);
        if (rst) begin
            modelClear();
        end else begin
            if (!mFq && f) mRises++;
            mFq = f;
            mIdx = c;
            mSeen[c] = 1'b1;
        end
        #1;
    endtask

    task automatic checkState(input string tag);
        total++;
        if (F_q !== mFq) begin
            bad++; $display("[TB] FAIL %s F_q got=%b exp=%b", tag, F_q, mFq);
        end
        total++;
        if (idx_q !== mIdx) begin
            bad++; $display("[TB] FAIL %s idx_q got=%0d exp=%0d", tag, idx_q, mIdx);
        end
        total++;
        if (seen !== mSeen || all_seen !== (mSeen == 8'hFF)) begin
            bad++; $display("[TB] FAIL %s seen got=%h/%b exp=%h", tag, seen, all_seen, mSeen);
        end
        total++;
        if (rise_cnt !== 8'(sat(mRises, 255)) || sRise !== 2'(sat(mRises, 3))) begin
            bad++; $display("[TB] FAIL %s rise_cnt got=%0d/%0d exp=%0d/%0d", tag, rise_cnt, sRise,
                            sat(mRises, 255), sat(mRises, 3));
        end
    endtask

    task automatic syncReset();
        rst = 1'b1;
        modelClear();
        clockEdge();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; {X, Y, Z} = 3'b000;
        modelClear();
        clockEdge();
        clockEdge();
        total++;
        if (F_q !== 1'b0 || seen !== 8'h00 || rise_cnt !== 8'd0 || all_seen !== 1'b0 || idx_q !== 3'd0) begin
            bad++; $display("[TB] FAIL reset F_q=%b seen=%h rise=%0d all=%b idx=%0d exp all zero",
                            F_q, seen, rise_cnt, all_seen, idx_q);
        end
    endtask

    // F is combinational, so it is swept while reset holds the registered state still.
    task automatic test_comb_sweep();
        for (int c = 0; c < 8; c++) begin
            {X, Y, Z} = 3'(c);
            #1;
            total++;
            if (F !== refF(3'(c))) begin
                bad++; $display("[TB] FAIL comb code=%0d F got=%b exp=%b", c, F, refF(3'(c)));
            end
            #9;
        end
        {X, Y, Z} = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reg_sweep();
        for (int c = 0; c < 8; c++) begin
            {X, Y, Z} = 3'(c);
            clockEdge();
            checkState($sformatf("regsweep%0d", c));
        end
        total++;
        if (seen !== 8'hFF || all_seen !== 1'b1 || rise_cnt !== 8'd2) begin
            bad++; $display("[TB] FAIL sweep_end seen=%h all=%b rise=%0d exp FF/1/2", seen, all_seen, rise_cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0] c;
        syncReset();
        for (int i = 0; i < 60; i++) begin
            // Glitch the inputs mid-cycle; only the final value before the edge is sampled.
            {X, Y, Z} = 3'($urandom_range(0, 7));
            #2;
            c = 3'($urandom_range(0, 7));
            {X, Y, Z} = c;
            #1;
            total++;
            if (F !== refF(c)) begin
                bad++; $display("[TB] FAIL rand_comb code=%0d F got=%b exp=%b", c, F, refF(c));
            end
            clockEdge();
            checkState($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_saturation();
        syncReset();
        for (int i = 0; i < 10; i++) begin
            {X, Y, Z} = (i % 2 == 0) ? 3'b111 : 3'b000;
            clockEdge();
        end
        checkState("saturate");
        total++;
        if (sRise !== 2'd3 || rise_cnt !== 8'd5) begin
            bad++; $display("[TB] FAIL saturate sat_cnt=%0d wide_cnt=%0d exp 3/5", sRise, rise_cnt);
        end
    endtask

    task automatic test_mid_reset();
        syncReset();
        for (int c = 0; c < 4; c++) begin
            {X, Y, Z} = 3'(c);
            clockEdge();
        end
        checkState("pre_reset");
        #2;
        rst = 1'b1;
        modelClear();
        #1;
        total++;
        if (seen !== 8'h00 || rise_cnt !== 8'd0 || F_q !== 1'b0) begin
            bad++; $display("[TB] FAIL async_reset seen=%h rise=%0d F_q=%b exp 00/0/0", seen, rise_cnt, F_q);
        end
        @(negedge clk);
        rst = 1'b0;
        {X, Y, Z} = 3'b100;
        clockEdge();
        checkState("resume");
        total++;
        if (seen !== 8'h10) begin
            bad++; $display("[TB] FAIL resume_seen got=%h exp=10", seen);
        end
    endtask

`ifdef TASK2_4_SOP_CHECK_EN
    task automatic test_sop_check();
        syncReset();
        for (int c = 0; c < 8; c++) begin
            {X, Y, Z} = 3'(c);
            clockEdge();
        end
        total++;
        if (err !== 1'b0) begin
            bad++; $display("[TB] FAIL sop_clean err got=%b exp=0", err);
        end
        {X, Y, Z} = 3'b000;
        force dut.fLut = 1'b1;
        clockEdge();
        release dut.fLut;
        clockEdge();
        clockEdge();
        total++;
        if (err !== 1'b1) begin
            bad++; $display("[TB] FAIL sop_sticky err got=%b exp=1", err);
        end
        syncReset();
        total++;
        if (err !== 1'b0) begin
            bad++; $display("[TB] FAIL sop_reset err got=%b exp=0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_comb_sweep();
        test_reg_sweep();
        test_random();
        test_saturation();
        test_mid_reset();
`ifdef TASK2_4_SOP_CHECK_EN
        test_sop_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
